// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg
// Shared definitions for the DDR request-to-command sequencer:
//   - bit positions of the commands understood by the Chip model
//   - sequencer FSM state encoding
//   - small constant helpers used to size counters
// Optional feature macro: DDR_SEQ_OPEN_PAGE_EN adds the OPEN state.
// ---------------------------------------------------------------------------
package ddr_pkg;

    localparam int CMD_WIDTH = 19;
    localparam int CMD_ACT   = 18;
    localparam int CMD_PR    = 7;
    localparam int CMD_RD    = 5;
    localparam int CMD_WR    = 1;

`ifdef DDR_SEQ_OPEN_PAGE_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACT   = 3'd1,
        ST_RCD   = 3'd2,
        ST_BURST = 3'd3,
        ST_RTP   = 3'd4,
        ST_PRE   = 3'd5,
        ST_RP    = 3'd6,
        ST_OPEN  = 3'd7
    } seq_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACT   = 3'd1,
        ST_RCD   = 3'd2,
        ST_BURST = 3'd3,
        ST_RTP   = 3'd4,
        ST_PRE   = 3'd5,
        ST_RP    = 3'd6
    } seq_state_e;
`endif

    // Larger of two non-negative constants, used to size the shared timer.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// ddr_cmd_seq_if
// Request handshake and Chip-facing command/address bundle of ddr_cmd_seq.
//   master : request producer (drives req_*, observes command stream)
//   slave  : the sequencer (drives req_ready, commands, bg/ba/row/column,
//            busy, done)
// ---------------------------------------------------------------------------
interface ddr_cmd_seq_if
    import ddr_pkg::*;
#(
    parameter int ADDRWIDTH     = 17,
    parameter int BANKGROUPS    = 2,
    parameter int BANKSPERGROUP = 2,
    parameter int COLS          = 1024
);
    localparam int BGW = $clog2(BANKGROUPS) + 1;
    localparam int BAW = $clog2(BANKSPERGROUP) + 1;
    localparam int CW  = $clog2(COLS);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [BGW-1:0]        req_bg;
    logic [BAW-1:0]        req_ba;
    logic [ADDRWIDTH-1:0]  req_row;
    logic [CW-1:0]         req_col;

    logic [CMD_WIDTH-1:0]  commands;
    logic [BGW-1:0]        bg;
    logic [BAW-1:0]        ba;
    logic [ADDRWIDTH-1:0]  row;
    logic [CW-1:0]         column;
    logic                  busy;
    logic                  done;

    modport master (
        output req_valid, req_write, req_bg, req_ba, req_row, req_col,
        input  req_ready, commands, bg, ba, row, column, busy, done
    );

    modport slave (
        input  req_valid, req_write, req_bg, req_ba, req_row, req_col,
        output req_ready, commands, bg, ba, row, column, busy, done
    );

endinterface

// File: rtl/ddr_seq_timer.sv
// ---------------------------------------------------------------------------
// ddr_seq_timer
// Loadable down-counter shared by the RCD, BURST, RTP and RP phases.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   halt       hold enable: count is frozen while high (load ignored)
//   load       load load_val on the next edge
//   load_val   value loaded (phase length minus one)
//   zero       high while the count is zero (last cycle of a phase)
// ---------------------------------------------------------------------------
module ddr_seq_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         halt,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Count register: halt wins over load, count saturates at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {W{1'b0}};
        end else if (halt) begin
            count_r <= count_r;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - W'(1);
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/ddr_cmd_seq.sv
// ---------------------------------------------------------------------------
// ddr_cmd_seq
// Expands one read/write burst request at a time into the timed
// ACT -> RD/WR burst -> PR command stream of the Chip DRAM model.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   halt   shared with Chip: freezes state, counters and addresses,
//          forces commands/done/req_ready low
//   bus    ddr_cmd_seq_if.slave: req_valid/req_ready handshake with
//          req_write/bg/ba/row/col, and commands/bg/ba/row/column/busy/done
// Optional feature macro: DDR_SEQ_OPEN_PAGE_EN keeps the row open after a
// burst (OPEN state); hits go straight to BURST, misses precharge first.
// ---------------------------------------------------------------------------
module ddr_cmd_seq
    import ddr_pkg::*;
#(
    parameter int ADDRWIDTH     = 17,
    parameter int BANKGROUPS    = 2,
    parameter int BANKSPERGROUP = 2,
    parameter int COLS          = 1024,
    parameter int BL            = 8,
    parameter int T_RCD         = 3,
    parameter int T_RTP         = 2,
    parameter int T_RP          = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         halt,
    ddr_cmd_seq_if.slave bus
);

    localparam int BGW  = $clog2(BANKGROUPS) + 1;
    localparam int BAW  = $clog2(BANKSPERGROUP) + 1;
    localparam int CW   = $clog2(COLS);
    localparam int TMAX = max2(max2(T_RCD, BL), max2(T_RTP, T_RP));
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] LD_RCD = TW'(T_RCD - 1);
    localparam logic [TW-1:0] LD_BL  = TW'(BL - 1);
    localparam logic [TW-1:0] LD_RTP = TW'((T_RTP > 0) ? (T_RTP - 1) : 0);
    localparam logic [TW-1:0] LD_RP  = TW'(T_RP - 1);
    localparam logic [CW-1:0] COL_ONE = CW'(1);

    // Where the FSM goes once the read/write-to-precharge gap has elapsed.
`ifdef DDR_SEQ_OPEN_PAGE_EN
    localparam seq_state_e RTP_EXIT = ST_OPEN;
`else
    localparam seq_state_e RTP_EXIT = ST_PRE;
`endif

    seq_state_e            state_r;
    seq_state_e            state_s;
    logic                  write_r;
    logic [BGW-1:0]        cur_bg_r;
    logic [BAW-1:0]        cur_ba_r;
    logic [ADDRWIDTH-1:0]  cur_row_r;
    logic [CW-1:0]         cur_col_r;
    logic [BGW-1:0]        bg_r,  bg_s;
    logic [BAW-1:0]        ba_r,  ba_s;
    logic [ADDRWIDTH-1:0]  row_r, row_s;
    logic [CW-1:0]         column_r, column_s;
    logic                  pend_r, pend_s;
    logic                  parked_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  tmr_load_s;
    logic [TW-1:0]         tmr_val_s;
    logic                  tmr_zero_s;
    logic [CMD_WIDTH-1:0]  cmd_s;
    logic                  done_s;

`ifdef DDR_SEQ_OPEN_PAGE_EN
    // The address outputs still carry the bank/row activated last, so they
    // double as the open-bank record while parked in OPEN.
    logic hit_s;
    assign hit_s    = (bus.req_bg == bg_r) && (bus.req_ba == ba_r) &&
                      (bus.req_row == row_r);
    assign parked_s = (state_r == ST_IDLE) || (state_r == ST_OPEN);
`else
    assign parked_s = (state_r == ST_IDLE);
`endif

    assign ready_s  = parked_s && !halt;
    assign accept_s = bus.req_valid && ready_s;

    ddr_seq_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .halt     (halt),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // State, captured request and address output registers; all frozen by halt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            write_r   <= 1'b0;
            cur_bg_r  <= {BGW{1'b0}};
            cur_ba_r  <= {BAW{1'b0}};
            cur_row_r <= {ADDRWIDTH{1'b0}};
            cur_col_r <= {CW{1'b0}};
            bg_r      <= {BGW{1'b0}};
            ba_r      <= {BAW{1'b0}};
            row_r     <= {ADDRWIDTH{1'b0}};
            column_r  <= {CW{1'b0}};
            pend_r    <= 1'b0;
        end else if (!halt) begin
            state_r  <= state_s;
            bg_r     <= bg_s;
            ba_r     <= ba_s;
            row_r    <= row_s;
            column_r <= column_s;
            pend_r   <= pend_s;
            if (accept_s) begin
                write_r   <= bus.req_write;
                cur_bg_r  <= bus.req_bg;
                cur_ba_r  <= bus.req_ba;
                cur_row_r <= bus.req_row;
                cur_col_r <= bus.req_col;
            end
        end
    end

    // Next-state, timer loads and next address-output values.
    always_comb begin
        state_s    = state_r;
        tmr_load_s = 1'b0;
        tmr_val_s  = {TW{1'b0}};
        bg_s       = bg_r;
        ba_s       = ba_r;
        row_s      = row_r;
        column_s   = column_r;
        pend_s     = pend_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ACT;
                    bg_s    = bus.req_bg;
                    ba_s    = bus.req_ba;
                    row_s   = bus.req_row;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACT: begin
                state_s    = ST_RCD;
                tmr_load_s = 1'b1;
                tmr_val_s  = LD_RCD;
            end
            ST_RCD: begin
                if (tmr_zero_s) begin
                    state_s    = ST_BURST;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_BL;
                    column_s   = cur_col_r;
                end else begin
                    state_s = ST_RCD;
                end
            end
            ST_BURST: begin
                // Column advances only on a completed beat, so a beat cut
                // short by halt is reissued with the same column.
                if (!tmr_zero_s) begin
                    column_s = column_r + COL_ONE;
                end else if (T_RTP > 0) begin
                    state_s    = ST_RTP;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_RTP;
                end else begin
                    state_s = RTP_EXIT;
                end
            end
            ST_RTP: begin
                if (tmr_zero_s) begin
                    state_s = RTP_EXIT;
                end else begin
                    state_s = ST_RTP;
                end
            end
            ST_PRE: begin
                // bg/ba still name the activated bank, i.e. the one closing.
                state_s    = ST_RP;
                tmr_load_s = 1'b1;
                tmr_val_s  = LD_RP;
            end
            ST_RP: begin
                if (!tmr_zero_s) begin
                    state_s = ST_RP;
                end else if (pend_r) begin
                    state_s = ST_ACT;
                    pend_s  = 1'b0;
                    bg_s    = cur_bg_r;
                    ba_s    = cur_ba_r;
                    row_s   = cur_row_r;
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef DDR_SEQ_OPEN_PAGE_EN
            ST_OPEN: begin
                if (!accept_s) begin
                    state_s = ST_OPEN;
                end else if (hit_s) begin
                    state_s    = ST_BURST;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_BL;
                    column_s   = bus.req_col;
                end else begin
                    // Miss: close the old bank, then activate the new row.
                    state_s = ST_PRE;
                    pend_s  = 1'b1;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Command vector and done pulse, silenced while halted.
    always_comb begin
        cmd_s  = {CMD_WIDTH{1'b0}};
        done_s = 1'b0;
        if (halt) begin
            cmd_s  = {CMD_WIDTH{1'b0}};
            done_s = 1'b0;
        end else begin
            case (state_r)
                ST_ACT: begin
                    cmd_s[CMD_ACT] = 1'b1;
                end
                ST_BURST: begin
                    if (write_r) begin
                        cmd_s[CMD_WR] = 1'b1;
                    end else begin
                        cmd_s[CMD_RD] = 1'b1;
                    end
                    done_s = tmr_zero_s;
                end
                ST_PRE: begin
                    cmd_s[CMD_PR] = 1'b1;
                end
                default: begin
                    cmd_s = {CMD_WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.commands  = cmd_s;
    assign bus.bg        = bg_r;
    assign bus.ba        = ba_r;
    assign bus.row       = row_r;
    assign bus.column    = column_r;
    assign bus.busy      = !parked_s;
    assign bus.done      = done_s;

endmodule

// File: tb/tb_ddr_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_ddr_cmd_seq
// Directed bench for ddr_cmd_seq. Stimulus pushes the expected command
// stream (cycle, command bits, address, done) into a queue when a request
// is issued; a monitor pops one entry whenever the DUT drives a non-zero
// command or done and compares it. Cycle numbers are counted at posedge.
// ---------------------------------------------------------------------------
module tb_ddr_cmd_seq;
    import ddr_pkg::*;

    localparam int AW    = 17;
    localparam int NBG   = 2;
    localparam int NBA   = 2;
    localparam int COLS  = 1024;
    localparam int BL    = 8;
    localparam int T_RCD = 3;
    localparam int T_RTP = 2;
    localparam int T_RP  = 3;
    localparam int HALT_LEN = 3;

    typedef struct {
        int          cyc;
        logic [18:0] cmd;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [16:0] row;
        logic [9:0]  col;
        bit          chk_col;
        logic        done;
    } exp_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic halt = 1'b0;
    int   cyc  = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   hs_cnt = 0;
    exp_t exp_q[$];
    exp_t e;

    ddr_cmd_seq_if #(
        .ADDRWIDTH(AW), .BANKGROUPS(NBG), .BANKSPERGROUP(NBA), .COLS(COLS)
    ) bus ();

    ddr_cmd_seq #(
        .ADDRWIDTH(AW), .BANKGROUPS(NBG), .BANKSPERGROUP(NBA), .COLS(COLS),
        .BL(BL), .T_RCD(T_RCD), .T_RTP(T_RTP), .T_RP(T_RP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .halt (halt),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every visible command/done must match the head of the queue.
    always @(negedge clk) begin
        if (rst === 1'b1 && (bus.commands !== 19'd0 || bus.done !== 1'b0)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_cmd: cycle %0d cmd %05h done %0b, nothing expected",
                         cyc, bus.commands, bus.done);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || bus.commands !== e.cmd || bus.bg !== e.bg ||
                    bus.ba !== e.ba || bus.row !== e.row || bus.done !== e.done ||
                    (e.chk_col && bus.column !== e.col)) begin
                    miscompares++;
                    $display("FAIL cmd_stream: got cyc %0d cmd %05h bg %0d ba %0d row %0h col %0d done %0b; expected cyc %0d cmd %05h bg %0d ba %0d row %0h col %0d done %0b",
                             cyc, bus.commands, bus.bg, bus.ba, bus.row, bus.column, bus.done,
                             e.cyc, e.cmd, e.bg, e.ba, e.row, e.col, e.done);
                end
            end
        end
    end

    // Handshake counter, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
            hs_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input int c, input int bit_idx, input logic [1:0] bg, input logic [1:0] ba,
                        input logic [16:0] row, input logic [9:0] col, input bit chk, input logic d);
        exp_t x;
        x.cyc = c;
        x.cmd = 19'd0;
        x.cmd[bit_idx] = 1'b1;
        x.bg = bg;
        x.ba = ba;
        x.row = row;
        x.col = col;
        x.chk_col = chk;
        x.done = d;
        exp_q.push_back(x);
    endtask

    // Expected ACT (optional) plus the BL beats for a request accepted at cycle a.
    task automatic push_seq(input int a, input bit wr, input logic [1:0] bg, input logic [1:0] ba,
                            input logic [16:0] row, input logic [9:0] col, input bit do_act,
                            input int halt_beat, output int last);
        int b0;
        int sh;
        logic [9:0] cc;
        if (do_act) begin
            push(a + 1, CMD_ACT, bg, ba, row, 10'd0, 1'b0, 1'b0);
            b0 = a + 2 + T_RCD;
        end else begin
            b0 = a + 1;
        end
        for (int i = 0; i < BL; i++) begin
            sh = (halt_beat >= 0 && i >= halt_beat) ? HALT_LEN : 0;
            cc = col + 10'(i);
            push(b0 + i + sh, wr ? CMD_WR : CMD_RD, bg, ba, row, cc, 1'b1, (i == BL - 1));
            last = b0 + i + sh;
        end
    endtask

    task automatic drive_req(input bit wr, input logic [1:0] bg, input logic [1:0] ba,
                             input logic [16:0] row, input logic [9:0] col);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_bg    = bg;
        bus.req_ba    = ba;
        bus.req_row   = row;
        bus.req_col   = col;
    endtask

    // Full closed-page request; optional halt of HALT_LEN cycles at a beat.
    task automatic req_closed(input bit wr, input logic [1:0] bg, input logic [1:0] ba,
                              input logic [16:0] row, input logic [9:0] col, input int halt_beat);
        int a;
        int last;
        int pr;
        int rdy;
        a = cyc;
        check("ready_at_accept", {31'd0, bus.req_ready}, 32'd1);
        drive_req(wr, bg, ba, row, col);
        push_seq(a, wr, bg, ba, row, col, 1'b1, halt_beat, last);
        pr = last + 1 + T_RTP;
        push(pr, CMD_PR, bg, ba, row, 10'd0, 1'b0, 1'b0);
        rdy = pr + 1 + T_RP;
        tick();
        bus.req_valid = 1'b0;
        if (halt_beat >= 0) begin
            wait_until(a + 2 + T_RCD + halt_beat);
            halt = 1'b1;
            #1;
            check("cmd_zero_in_halt", {13'd0, bus.commands}, 32'd0);
            check("ready_low_in_halt", {31'd0, bus.req_ready}, 32'd0);
            repeat (HALT_LEN) tick();
            halt = 1'b0;
        end
        wait_until(rdy - 1);
        check("ready_low_before_end", {31'd0, bus.req_ready}, 32'd0);
        check("busy_before_end", {31'd0, bus.busy}, 32'd1);
        tick();
        check("ready_back", {31'd0, bus.req_ready}, 32'd1);
        check("busy_clear", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a;
        int last;
        int hs0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_bg    = 2'd0;
        bus.req_ba    = 2'd0;
        bus.req_row   = 17'd0;
        bus.req_col   = 10'd0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Reset state
        check("rst_commands", {13'd0, bus.commands}, 32'd0);
        check("rst_bg", {30'd0, bus.bg}, 32'd0);
        check("rst_ba", {30'd0, bus.ba}, 32'd0);
        check("rst_row", {15'd0, bus.row}, 32'd0);
        check("rst_column", {22'd0, bus.column}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);

`ifdef DDR_SEQ_OPEN_PAGE_EN
        // First request opens row 20 in bg1/ba0 and parks in OPEN.
        a = cyc;
        drive_req(1'b0, 2'd1, 2'd0, 17'd20, 10'd8);
        push_seq(a, 1'b0, 2'd1, 2'd0, 17'd20, 10'd8, 1'b1, -1, last);
        tick();
        bus.req_valid = 1'b0;
        wait_until(last + T_RTP);
        check("open_ready_low", {31'd0, bus.req_ready}, 32'd0);
        tick();
        check("open_ready", {31'd0, bus.req_ready}, 32'd1);
        check("open_busy", {31'd0, bus.busy}, 32'd0);
        repeat (4) tick();
        // Hit: burst starts one cycle after acceptance, no ACT.
        a = cyc;
        drive_req(1'b1, 2'd1, 2'd0, 17'd20, 10'd16);
        push_seq(a, 1'b1, 2'd1, 2'd0, 17'd20, 10'd16, 1'b0, -1, last);
        tick();
        bus.req_valid = 1'b0;
        wait_until(last + 1 + T_RTP);
        check("hit_ready", {31'd0, bus.req_ready}, 32'd1);
        // Miss: PR of the old bank/row, T_RP, then ACT of the new row.
        a = cyc;
        drive_req(1'b0, 2'd0, 2'd1, 17'd21, 10'd1022);
        push(a + 1, CMD_PR, 2'd1, 2'd0, 17'd20, 10'd0, 1'b0, 1'b0);
        push_seq(a + 1 + T_RP, 1'b0, 2'd0, 2'd1, 17'd21, 10'd1022, 1'b1, -1, last);
        tick();
        bus.req_valid = 1'b0;
        wait_until(last + 1 + T_RTP);
        check("miss_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (3) tick();
`else
        // Closed-page read with column wrap.
        req_closed(1'b0, 2'd0, 2'd1, 17'd5, 10'd1020, -1);
        // Write row 1 col 0.
        req_closed(1'b1, 2'd1, 2'd0, 17'd1, 10'd0, -1);
        // Halt during beat 3.
        req_closed(1'b0, 2'd1, 2'd1, 17'h0abcd, 10'd0, 3);

        // Reset pulsed during RCD.
        a = cyc;
        drive_req(1'b1, 2'd1, 2'd1, 17'h1abcd, 10'd40);
        push(a + 1, CMD_ACT, 2'd1, 2'd1, 17'h1abcd, 10'd0, 1'b0, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        wait_until(a + 2);
        rst = 1'b0;
        #1;
        check("midrst_commands", {13'd0, bus.commands}, 32'd0);
        check("midrst_bg", {30'd0, bus.bg}, 32'd0);
        check("midrst_ba", {30'd0, bus.ba}, 32'd0);
        check("midrst_row", {15'd0, bus.row}, 32'd0);
        check("midrst_column", {22'd0, bus.column}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_queue", exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        req_closed(1'b0, 2'd0, 2'd0, 17'd77, 10'd512, -1);

        // req_valid held high: one acceptance per full sequence.
        a = cyc;
        hs0 = hs_cnt;
        drive_req(1'b0, 2'd0, 2'd0, 17'd9, 10'd100);
        push_seq(a, 1'b0, 2'd0, 2'd0, 17'd9, 10'd100, 1'b1, -1, last);
        push(last + 1 + T_RTP, CMD_PR, 2'd0, 2'd0, 17'd9, 10'd0, 1'b0, 1'b0);
        push_seq(a + 19, 1'b0, 2'd0, 2'd0, 17'd9, 10'd100, 1'b1, -1, last);
        push(last + 1 + T_RTP, CMD_PR, 2'd0, 2'd0, 17'd9, 10'd0, 1'b0, 1'b0);
        wait_until(a + 20);
        bus.req_valid = 1'b0;
        check("b2b_handshakes", hs_cnt - hs0, 32'd2);
        wait_until(a + 38);
        check("b2b_ready_back", {31'd0, bus.req_ready}, 32'd1);
        check("b2b_handshakes_end", hs_cnt - hs0, 32'd2);
`endif
        repeat (2) tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
